fp_unit_arbiter: RTL and testbench
==================================

# fp_unit_arbiter

Round-robin arbiter that shares one handshake-based floating-point unit (the `multiplier` or `adder` core, stb/ack on both operands and the result) among N requesters. It grants one two-operand operation at a time, pulses the unit's reset before each operation, forwards operands, and returns the result to the granted requester. It sits between matrix-engine sequencers and a single shared FP core, so several sequencers can use one multiplier or adder.

## Interface
- N, 4: number of requesters, legal range 2..8.
- GW, $clog2(N): grant index width.
- clk  in  1  rising-edge clock.
- rst  in  1  active-low, synchronous reset.
- req_a  in  32*N  operand A per requester; requester r uses bits [32r+31:32r].
- req_b  in  32*N  operand B per requester.
- req_stb  in  N  per-requester request strobe.
- req_ack  out  N  one-cycle pulse: operands captured.
- res_z  out  32  result, valid while any res_stb bit is high.
- res_stb  out  N  result-valid strobe; only the granted bit is ever high.
- res_ack  in  N  requester accepts the result.
- unit_a, unit_b  out  32  latched operands to the FP core.
- unit_a_stb, unit_b_stb  out  1  operand strobes to the core.
- unit_a_ack, unit_b_ack  in  1  operand acks from the core.
- unit_z  in  32  core result.
- unit_z_stb  in  1  core result valid.
- unit_z_ack  out  1  one-cycle result ack to the core.
- unit_rst  out  1  active-high reset to the core.
- busy  out  1  high in every state except S_IDLE.
- grant_id  out  GW  index of the current or most recent grant.
- ops_count  out  16  completed operations; wraps at 0xFFFF to 0.

## Operation
- Reset (rst==0 at a posedge, in any state): state goes to S_IDLE and ptr to 0. Reset values: req_ack, res_stb, unit_a_stb, unit_b_stb, unit_z_ack = 0; unit_rst = 1; res_z, unit_a, unit_b, grant_id, ops_count = 0; busy = 0. An in-flight operation is abandoned and its result is never delivered.
- unit_rst = 1 in S_IDLE and S_RESET, and 0 in every other state.
- S_IDLE:
  - If any req_stb bit is high, select the first set bit searching from ptr upward, wrapping modulo N.
  - Latch req_a/req_b of the winner into unit_a/unit_b, set grant_id = g, pulse req_ack[g] for one cycle, then go to S_RESET.
- S_RESET: one cycle, then go to S_SEND_A.
- S_SEND_A: unit_a_stb = 1. On a cycle with unit_a_ack sampled high, clear unit_a_stb and go to S_SEND_B.
- S_SEND_B: same as S_SEND_A, using unit_b_stb and unit_b_ack, then go to S_WAIT_Z.
- S_WAIT_Z: on unit_z_stb, set res_z = unit_z, pulse unit_z_ack for exactly one cycle, set res_stb[g] = 1, and go to S_DELIVER.
- S_DELIVER:
  - Hold res_stb[g] and res_z stable.
  - On res_ack[g]: clear res_stb, set ptr = (g+1) mod N, increment ops_count, and go to S_IDLE.
  - res_ack bits of non-granted requesters are ignored.
- req_stb is only sampled in S_IDLE. A requester whose req_stb is still high after its req_ack is treated as issuing a new request.
- No operand or result arithmetic is done here; values pass through unchanged.

## Timing
- All outputs are registered.
- Request latency: req_stb high in S_IDLE at edge 0 gives req_ack and unit_rst=1 in cycle 1 (S_RESET), and unit_a_stb=1 from edge 2.
- Minimum cycles from grant to S_WAIT_Z with zero-wait acks is 4.
- Result: unit_z_stb sampled at edge t gives res_stb/res_z valid and unit_z_ack=1 from t+1; unit_z_ack is low again from t+2.
- res_ack sampled at edge u clears res_stb from u+1. The next grant is decided at u+1, so there is at least one S_IDLE cycle between operations.
- A request that arrives in the same cycle as res_ack waits for that S_IDLE cycle; priority uses the updated ptr.
- Strobes stay asserted for as long as their ack stays low; there is no timeout.

## Test plan
- Single request: r1 sends a=0x40000000, b=0x40400000; the bench core model returns 0x40C00000 after 5 cycles. Check: req_ack[1] pulses once, unit_rst is high for 2 cycles, res_stb[1] goes high with res_z=0x40C00000, and ops_count becomes 1.
- Simultaneous requests: all four req_stb high and held after reset. Grants must be 0,1,2,3,0 in that order, and grant_id must match each grant.
- Priority after wrap: r3 is served, then r0 and r2 request together. r0 must win because ptr is 0 after 3.
- Result backpressure: hold res_ack[2] low for 10 cycles. res_stb[2] and res_z must stay stable, unit_z_ack must pulse exactly once, and busy must stay 1.
- Reset mid-operation: drop rst for 1 cycle in S_WAIT_Z. Check: all strobes are 0, unit_rst=1, busy=0, ops_count=0, and no res_stb follows even if the model later asserts unit_z_stb.
- Ignored ack: assert res_ack[0] while r1 holds the grant. State must not change until res_ack[1] arrives.

Source files
------------

// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one stb/ack floating-point core among N requesters.
// Each grant resets the core, forwards both operands, and returns the result to the winner.
module fp_unit_arbiter #(
    parameter int N  = 4,
    parameter int GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [32*N-1:0] req_a,
    input  logic [32*N-1:0] req_b,
    input  logic [N-1:0]    req_stb,
    output logic [N-1:0]    req_ack,
    output logic [31:0]     res_z,
    output logic [N-1:0]    res_stb,
    input  logic [N-1:0]    res_ack,
    output logic [31:0]     unit_a,
    output logic [31:0]     unit_b,
    output logic            unit_a_stb,
    output logic            unit_b_stb,
    input  logic            unit_a_ack,
    input  logic            unit_b_ack,
    input  logic [31:0]     unit_z,
    input  logic            unit_z_stb,
    output logic            unit_z_ack,
    output logic            unit_rst,
    output logic            busy,
    output logic [GW-1:0]   grant_id,
    output logic [15:0]     ops_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_SEND_A  = 3'd2,
        S_SEND_B  = 3'd3,
        S_WAIT_Z  = 3'd4,
        S_DELIVER = 3'd5
    } state_t;

    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    state_t        state_r;
    logic [GW-1:0] ptr_r;
    logic          any_req_s;
    logic [GW-1:0] win_s;
    logic [GW-1:0] next_ptr_s;

    // First requesting index at or after ptr, wrapping modulo N.
    always_comb begin
        any_req_s = 1'b0;
        win_s     = '0;
        for (int i = 0; i < N; i++) begin : scan
            int            idx;
            logic [GW-1:0] idx_n;
            logic          hit;
            idx       = (int'(ptr_r) + i) % N;
            idx_n     = GW'(idx);
            hit       = !any_req_s && req_stb[idx_n];
            any_req_s = any_req_s | hit;
            win_s     = hit ? idx_n : win_s;
        end
    end

    // Pointer advances past the requester that just completed.
    always_comb begin
        if (grant_id == GW'(N - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_id + GW'(1);
        end
    end

    // Grant/handshake sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            ptr_r      <= '0;
            req_ack    <= '0;
            res_stb    <= '0;
            unit_a_stb <= 1'b0;
            unit_b_stb <= 1'b0;
            unit_z_ack <= 1'b0;
            unit_rst   <= 1'b1;
            res_z      <= 32'd0;
            unit_a     <= 32'd0;
            unit_b     <= 32'd0;
            grant_id   <= '0;
            ops_count  <= 16'd0;
            busy       <= 1'b0;
        end else begin
            req_ack    <= '0;
            unit_z_ack <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    unit_rst <= 1'b1;
                    if (any_req_s) begin
                        unit_a   <= req_a[32*int'(win_s) +: 32];
                        unit_b   <= req_b[32*int'(win_s) +: 32];
                        grant_id <= win_s;
                        req_ack  <= ONE_HOT0 << win_s;
                        busy     <= 1'b1;
                        state_r  <= S_RESET;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_RESET: begin
                    unit_rst <= 1'b0;
                    state_r  <= S_SEND_A;
                end
                // The B strobe is raised on the A handshake edge to save a cycle.
                S_SEND_A: begin
                    if (unit_a_stb && unit_a_ack) begin
                        unit_a_stb <= 1'b0;
                        unit_b_stb <= 1'b1;
                        state_r    <= S_SEND_B;
                    end else begin
                        unit_a_stb <= 1'b1;
                    end
                end
                S_SEND_B: begin
                    if (unit_b_stb && unit_b_ack) begin
                        unit_b_stb <= 1'b0;
                        state_r    <= S_WAIT_Z;
                    end else begin
                        unit_b_stb <= 1'b1;
                    end
                end
                S_WAIT_Z: begin
                    if (unit_z_stb) begin
                        res_z      <= unit_z;
                        unit_z_ack <= 1'b1;
                        res_stb    <= ONE_HOT0 << grant_id;
                        state_r    <= S_DELIVER;
                    end else begin
                        state_r <= S_WAIT_Z;
                    end
                end
                S_DELIVER: begin
                    if (res_ack[grant_id]) begin
                        res_stb   <= '0;
                        ptr_r     <= next_ptr_s;
                        ops_count <= ops_count + 16'd1;
                        busy      <= 1'b0;
                        unit_rst  <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        state_r <= S_DELIVER;
                    end
                end
                default: begin
                    res_stb    <= '0;
                    unit_a_stb <= 1'b0;
                    unit_b_stb <= 1'b0;
                    unit_rst   <= 1'b1;
                    busy       <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter with a small zero-wait FP core model.
module tb_fp_unit_arbiter;

    localparam int N  = 4;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [32*N-1:0] req_a, req_b;
    logic [N-1:0]    req_stb, req_ack, res_stb, res_ack;
    logic [31:0]     res_z, unit_a, unit_b, unit_z;
    logic            unit_a_stb, unit_b_stb, unit_a_ack, unit_b_ack;
    logic            unit_z_stb, unit_z_ack, unit_rst, busy;
    logic [GW-1:0]   grant_id;
    logic [15:0]     ops_count;

    int          checks = 0;
    int          failures = 0;
    logic        model_clear;
    logic [31:0] z_val;
    int          z_delay;
    logic [31:0] cap_a, cap_b;
    logic        zpend;
    int          zcnt;
    logic        saw_z;

    fp_unit_arbiter #(.N(N), .GW(GW)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_stb(req_stb),
        .req_ack(req_ack), .res_z(res_z), .res_stb(res_stb), .res_ack(res_ack),
        .unit_a(unit_a), .unit_b(unit_b), .unit_a_stb(unit_a_stb), .unit_b_stb(unit_b_stb),
        .unit_a_ack(unit_a_ack), .unit_b_ack(unit_b_ack), .unit_z(unit_z),
        .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack), .unit_rst(unit_rst),
        .busy(busy), .grant_id(grant_id), .ops_count(ops_count)
    );

    always #5 clk = ~clk;

    // Core model: acks operands at once, answers z_delay cycles after operand B.
    assign unit_a_ack = unit_a_stb;
    assign unit_b_ack = unit_b_stb;

    always @(posedge clk) begin
        if (model_clear) begin
            zpend      <= 1'b0;
            zcnt       <= 0;
            unit_z_stb <= 1'b0;
            unit_z     <= 32'd0;
        end else begin
            if (unit_a_stb && unit_a_ack) cap_a <= unit_a;
            if (unit_b_stb && unit_b_ack) begin
                cap_b <= unit_b;
                zpend <= 1'b1;
                zcnt  <= z_delay;
            end else if (zpend) begin
                if (zcnt == 0) begin
                    unit_z_stb <= 1'b1;
                    unit_z     <= z_val;
                    zpend      <= 1'b0;
                end else begin
                    zcnt <= zcnt - 1;
                end
            end
            if (unit_z_stb && unit_z_ack) unit_z_stb <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_a(input int r);
        if (r == 1) return 32'h4000_0000;
        else        return 32'h3F80_0000 | 32'(r);
    endfunction

    function automatic logic [31:0] exp_b(input int r);
        if (r == 1) return 32'h4040_0000;
        else        return 32'h4000_0000 | 32'(r);
    endfunction

    task automatic wait_ack;
        int n = 0;
        while (req_ack == '0 && n < 20) begin tick; n++; end
    endtask

    task automatic wait_res;
        int n = 0;
        while (res_stb == '0 && n < 60) begin tick; n++; end
    endtask

    // One full operation for requester g; clear_mask drops req_stb bits after the grant.
    task automatic serve(input int g, input logic [N-1:0] clear_mask, input logic [31:0] zv);
        logic [N-1:0] m;
        m     = 4'b0001 << g;
        z_val = zv;
        wait_ack;
        check("grant_req_ack", 32'(req_ack), 32'(m));
        check("grant_id", 32'(grant_id), 32'(g));
        check("grant_unit_a", unit_a, exp_a(g));
        req_stb = req_stb & ~clear_mask;
        tick;
        check("req_ack_single", 32'(req_ack), 32'd0);
        wait_res;
        check("res_stb", 32'(res_stb), 32'(m));
        check("res_z", res_z, zv);
        check("z_ack_pulse", 32'(unit_z_ack), 32'd1);
        res_ack = m;
        tick;
        res_ack = '0;
        check("res_stb_clear", 32'(res_stb), 32'd0);
    endtask

    initial begin
        rst = 1'b0; req_stb = '0; res_ack = '0; model_clear = 1'b1;
        z_val = 32'd0; z_delay = 2; saw_z = 1'b0;
        for (int r = 0; r < N; r++) begin
            req_a[32*r +: 32] = exp_a(r);
            req_b[32*r +: 32] = exp_b(r);
        end
        tick; tick;
        model_clear = 1'b0;
        check("rst_req_ack", 32'(req_ack), 32'd0);
        check("rst_res_stb", 32'(res_stb), 32'd0);
        check("rst_a_stb", 32'(unit_a_stb), 32'd0);
        check("rst_b_stb", 32'(unit_b_stb), 32'd0);
        check("rst_z_ack", 32'(unit_z_ack), 32'd0);
        check("rst_unit_rst", 32'(unit_rst), 32'd1);
        check("rst_res_z", res_z, 32'd0);
        check("rst_unit_a", unit_a, 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_ops", 32'(ops_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick;

        // Single request from r1 with cycle-level timing.
        z_val = 32'h40C0_0000; z_delay = 5; req_stb = 4'b0010;
        tick;
        check("t1_req_ack", 32'(req_ack), 32'h2);
        check("t1_grant", 32'(grant_id), 32'd1);
        check("t1_rst_hi", 32'(unit_rst), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_unit_a", unit_a, 32'h4000_0000);
        check("t1_unit_b", unit_b, 32'h4040_0000);
        req_stb = '0;
        tick;
        check("t1_req_ack_low", 32'(req_ack), 32'd0);
        check("t1_rst_lo", 32'(unit_rst), 32'd0);
        check("t1_a_stb_late", 32'(unit_a_stb), 32'd0);
        tick;
        check("t1_a_stb", 32'(unit_a_stb), 32'd1);
        tick;
        check("t1_a_stb_drop", 32'(unit_a_stb), 32'd0);
        check("t1_b_stb", 32'(unit_b_stb), 32'd1);
        tick;
        check("t1_b_stb_drop", 32'(unit_b_stb), 32'd0);
        wait_res;
        check("t1_res_stb", 32'(res_stb), 32'h2);
        check("t1_res_z", res_z, 32'h40C0_0000);
        check("t1_z_ack", 32'(unit_z_ack), 32'd1);
        check("t1_cap_a", cap_a, 32'h4000_0000);
        check("t1_cap_b", cap_b, 32'h4040_0000);
        tick;
        check("t1_z_ack_low", 32'(unit_z_ack), 32'd0);
        check("t1_res_hold", 32'(res_stb), 32'h2);
        res_ack = 4'b0010;
        tick;
        res_ack = '0;
        check("t1_res_clear", 32'(res_stb), 32'd0);
        check("t1_ops", 32'(ops_count), 32'd1);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_rst", 32'(unit_rst), 32'd1);

        // Ack from a non-granted requester is ignored.
        z_delay = 2; req_stb = 4'b0010; z_val = 32'h1111_2222;
        wait_ack;
        check("t6_req_ack", 32'(req_ack), 32'h2);
        req_stb = '0;
        wait_res;
        check("t6_res_stb", 32'(res_stb), 32'h2);
        res_ack = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("t6_hold_stb", 32'(res_stb), 32'h2);
            check("t6_hold_ops", 32'(ops_count), 32'd1);
        end
        res_ack = 4'b0010;
        tick;
        res_ack = '0;
        check("t6_clear", 32'(res_stb), 32'd0);
        check("t6_ops", 32'(ops_count), 32'd2);

        // Result backpressure on r2.
        req_stb = 4'b0100; z_val = 32'hABCD_1234;
        wait_ack;
        check("t4_grant", 32'(grant_id), 32'd2);
        req_stb = '0;
        wait_res;
        check("t4_res_stb", 32'(res_stb), 32'h4);
        check("t4_z_ack", 32'(unit_z_ack), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick;
            check("t4_hold_stb", 32'(res_stb), 32'h4);
            check("t4_hold_z", res_z, 32'hABCD_1234);
            check("t4_z_ack_once", 32'(unit_z_ack), 32'd0);
            check("t4_busy", 32'(busy), 32'd1);
        end
        res_ack = 4'b0100;
        tick;
        res_ack = '0;
        check("t4_ops", 32'(ops_count), 32'd3);

        // Priority after wrap: r3, then r0 beats r2.
        req_stb = 4'b1000;
        serve(3, 4'b1000, 32'h3333_0003);
        req_stb = 4'b0101;
        tick;
        serve(0, 4'b0001, 32'h0000_0A00);
        serve(2, 4'b0100, 32'h0000_0A02);
        check("t3_ops", 32'(ops_count), 32'd6);

        // Reset while waiting for the core result.
        z_delay = 5; req_stb = 4'b0010; z_val = 32'hDEAD_BEEF;
        wait_ack;
        req_stb = '0;
        begin
            int n = 0;
            while (!unit_b_stb && n < 20) begin tick; n++; end
        end
        check("t5_b_stb_seen", 32'(unit_b_stb), 32'd1);
        tick;
        check("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check("t5_a_stb", 32'(unit_a_stb), 32'd0);
        check("t5_b_stb", 32'(unit_b_stb), 32'd0);
        check("t5_res_stb", 32'(res_stb), 32'd0);
        check("t5_req_ack", 32'(req_ack), 32'd0);
        check("t5_z_ack", 32'(unit_z_ack), 32'd0);
        check("t5_unit_rst", 32'(unit_rst), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ops", 32'(ops_count), 32'd0);
        check("t5_grant", 32'(grant_id), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick;
            saw_z = saw_z | unit_z_stb;
            check("t5_no_res", 32'(res_stb), 32'd0);
            check("t5_no_z_ack", 32'(unit_z_ack), 32'd0);
        end
        check("t5_model_z", 32'(saw_z), 32'd1);
        model_clear = 1'b1;
        tick;
        model_clear = 1'b0;

        // All four held after reset: grants 0,1,2,3,0.
        z_delay = 2; req_stb = 4'b1111;
        serve(0, 4'b0000, 32'h5000_0000);
        serve(1, 4'b0000, 32'h5000_0001);
        serve(2, 4'b0000, 32'h5000_0002);
        serve(3, 4'b0000, 32'h5000_0003);
        serve(0, 4'b1111, 32'h5000_0010);
        check("t2_ops", 32'(ops_count), 32'd5);
        check("t2_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
